hb_decim2: RTL and testbench
============================

# hb_decim2

Half-band FIR decimate-by-2 stage that sits directly downstream of the integrator-comb decimator. It consumes the signed CIC output samples and their valid pulses, and applies an 11-tap half-band low-pass with unity DC gain. It emits one rounded, saturated sample for every two accepted inputs. A single time-shared multiplier evaluates the 7 non-zero taps serially, so the block has a ready/valid input handshake and a sticky overrun flag.

## Interface
- IN_WIDTH, 22: input sample width (signed); matches the CIC output for ORDER=3, R=64.
- OUT_WIDTH, 22: output sample width (signed), must be <= IN_WIDTH + 1.
- COEF_WIDTH, 16: coefficient width (signed Q1.15).
- clk  input  1  clock; one clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  IN_WIDTH  signed sample (CIC output).
- in_valid  input  1  sample strobe (CIC output valid).
- in_ready  output  1  high when the block can accept a sample.
- out_data  output  OUT_WIDTH  signed filtered/decimated sample.
- out_valid  output  1  one-cycle pulse per output sample.
- overrun  output  1  sticky: a sample arrived while in_ready was low.
- overrun_clr  input  1  synchronous clear of overrun.

## Operation
- Coefficients h[0..10] are fixed: 512, 0, -2560, 0, 10240, 16384, 10240, 0, -2560, 0, 512. They sum to 32768, so DC gain is exactly 1.
- The sample buffer is an 11-deep shift register x[0..10], where x[0] holds the newest sample. It is zero at reset.
- A sample is accepted when in_valid && in_ready. On acceptance, x shifts in the sample and the phase bit toggles.
- An output is computed after every second accepted sample: the 2nd, 4th, … after reset.
- FSM states: IDLE, MAC, OUT.
- IDLE -> MAC on an accepted sample that sets phase=0 (completing a pair). The accumulator clears and the tap index resets.
- An accepted sample that sets phase=1 stays in IDLE and only shifts.
- MAC runs for 7 cycles over taps {0,2,4,5,6,8,10}, one multiply-accumulate per cycle: acc += h[k]*x[k]. Zero taps are skipped.
- MAC -> OUT after the 7th tap. OUT -> IDLE unconditionally.
- Accumulator width is IN_WIDTH + COEF_WIDTH + 2, signed, with no internal overflow.
- Output in OUT: y = (acc + 2^14) >>> 15 (round half up, arithmetic shift), then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- in_ready = (state == IDLE), combinational from the state register.
- When in_valid is high and in_ready is low, the sample is dropped: x, phase, and the FSM are untouched, and overrun is set.
- overrun_clr clears overrun. If a drop happens in the same cycle as overrun_clr, the set wins.
- Reset mid-computation aborts the computation. x, acc, phase, and the FSM return to zero/IDLE, and no out_valid is produced.

## Timing
- Reset values: out_data=0, out_valid=0, overrun=0, in_ready=1 (IDLE), phase=0.
- The pair-completing sample is accepted at edge N. MAC accumulates at edges N+1..N+7. OUT registers out_data and out_valid=1 at edge N+8. out_valid is high for exactly one cycle, N+8 to N+9.
- in_ready is low from after edge N until after edge N+8. It is high again for the cycle following N+8. The minimum spacing between pair-completing samples is 9 cycles.
- out_data holds its value between pulses.
- Upstream CIC spacing is R×(input spacing) ≥ 64 cycles, so overrun never occurs in nominal operation.

## Test plan
- Reset check: assert rst_n low mid-MAC -> outputs return to their reset values, out_valid is never asserted, and in_ready=1 on the cycle after release.
- Impulse: accepted samples 0, 32768, 0, 0, … (12 samples) -> six out_valid pulses with out_data = 512, -2560, 10240, 10240, -2560, 512.
- DC: a constant 10000 stream -> after the 6th output, every out_data is 10000. Repeat with 2097151 -> 2097151 (no false saturation).
- Saturation: for an output index n, drive x[n-k] = +2097151 for k in {0,4,5,6,10}, -2097152 for k in {2,8}, and 0 otherwise -> out_data = 2097151. Drive the mirrored pattern -> -2097152.
- Handshake/overrun: assert in_valid two cycles after a pair-completing acceptance -> sample dropped, overrun=1 sticky, and the next output is unchanged versus a golden model. Pulse overrun_clr -> overrun=0.
- Latency: measure from the accepting edge to the out_valid edge -> exactly 8 cycles. in_ready is low for exactly 8 cycles. Back-to-back pairs at 9-cycle spacing -> no drops.

Source files
------------

// File: rtl/hb_decim2.sv
// 11-tap half-band FIR, decimate-by-2, unity DC gain. One shared multiplier walks
// the seven non-zero taps serially; the input side uses a ready/valid handshake.
module hb_decim2 #(
    parameter int IN_WIDTH   = 22,
    parameter int OUT_WIDTH  = 22,
    parameter int COEF_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int PROD_W = IN_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = IN_WIDTH + COEF_WIDTH + 2;

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                      state_q;
    logic                        phase_q;
    logic [2:0]                  tap_q;
    logic signed [IN_WIDTH-1:0]  x_q [0:10];
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     acc_d;
    logic signed [IN_WIDTH-1:0]  x_sel;
    logic signed [PROD_W-1:0]    prod;
    logic [OUT_WIDTH-1:0]        out_data_q;
    logic                        out_valid_q;
    logic                        overrun_q;

    // Buffer position of the t-th non-zero tap; the zero odd taps are never visited.
    function automatic logic [3:0] tap_pos(input logic [2:0] t);
        case (t)
            3'd0:    return 4'd0;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd5;
            3'd4:    return 4'd6;
            3'd5:    return 4'd8;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic signed [COEF_WIDTH-1:0] tap_coef(input logic [2:0] t);
        case (t)
            3'd0:    return COEF_WIDTH'(512);
            3'd1:    return COEF_WIDTH'(-2560);
            3'd2:    return COEF_WIDTH'(10240);
            3'd3:    return COEF_WIDTH'(16384);
            3'd4:    return COEF_WIDTH'(10240);
            3'd5:    return COEF_WIDTH'(-2560);
            default: return COEF_WIDTH'(512);
        endcase
    endfunction

    // Round half up out of Q15, then clamp to the output range.
    function automatic logic [OUT_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + ACC_W'(16384)) >>> 15;
        if (r > OUT_MAX)      return OUT_MAX[OUT_WIDTH-1:0];
        else if (r < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
        else                  return r[OUT_WIDTH-1:0];
    endfunction

    always_comb begin
        x_sel = x_q[tap_pos(tap_q)];
        prod  = PROD_W'(x_sel) * PROD_W'(tap_coef(tap_q));
        acc_d = acc_q + ACC_W'(prod);
    end

    assign in_ready  = (state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            tap_q       <= 3'd0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 11; i++) x_q[i] <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid && !in_ready)  overrun_q <= 1'b1;
            else if (overrun_clr)       overrun_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q[0] <= in_data;
                        for (int i = 1; i < 11; i++) x_q[i] <= x_q[i-1];
                        phase_q <= ~phase_q;
                        if (phase_q) begin
                            state_q <= MAC;
                            acc_q   <= '0;
                            tap_q   <= 3'd0;
                        end
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    tap_q <= tap_q + 3'd1;
                    if (tap_q == 3'd6) state_q <= OUT;
                end
                OUT: begin
                    out_data_q  <= round_sat(acc_q);
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hb_decim2.sv
// Directed bench for hb_decim2: reset, impulse, rounding, DC, saturation,
// overrun handling, latency and back-to-back pairs.
module tb_hb_decim2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] out_data;
    logic        out_valid;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic signed [21:0] outq[$];
    int                 outcyc[$];
    int                 accq[$];

    hb_decim2 #(.IN_WIDTH(22), .OUT_WIDTH(22), .COEF_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            outq.push_back($signed(out_data));
            outcyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        in_valid = 1'b0;
        overrun_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        outq.delete();
        outcyc.delete();
        accq.delete();
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data = 22'(v);
        @(posedge clk);
        #1;
        accq.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (outq.size() < n && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (out_data !== 22'd0) begin fails++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun: got %0b required 0", overrun); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
        rst_n = 1'b1;
        send(0);
        send(64);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready: got %0b required 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready: got %0b required 1", in_ready); end
        repeat (12) @(negedge clk);
        tests++; if (outq.size() !== 0) begin fails++; $display("FAIL rst_abort_no_output: got %0d pulses required 0", outq.size()); end
        tests++; if (out_data !== 22'd0) begin fails++; $display("FAIL rst_abort_out_data: got %0d required 0", out_data); end
        send(0);
        send(0);
        wait_out(1);
        tests++; if (outq.size() !== 1) begin fails++; $display("FAIL rst_after_count: got %0d required 1", outq.size()); end
        tests++; if (outq[0] !== 22'sd0) begin fails++; $display("FAIL rst_buffer_cleared: got %0d required 0", outq[0]); end
    endtask

    task automatic test_impulse();
        int exp_v[6];
        exp_v = '{512, -2560, 10240, 10240, -2560, 512};
        do_reset();
        for (int i = 0; i < 12; i++) send(i == 1 ? 32768 : 0);
        wait_out(6);
        tests++; if (outq.size() !== 6) begin fails++; $display("FAIL impulse_count: got %0d required 6", outq.size()); end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (outq[i] !== 22'(exp_v[i])) begin
                fails++; $display("FAIL impulse_%0d: got %0d required %0d", i, outq[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_rounding();
        int vin[5];
        int vexp[5];
        vin  = '{32, -32, -33, 31, 64};
        vexp = '{1, 0, -1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            send(0);
            send(vin[i]);
            wait_out(1);
            tests++;
            if (outq[0] !== 22'(vexp[i])) begin
                fails++; $display("FAIL round_in%0d: got %0d required %0d", vin[i], outq[0], vexp[i]);
            end
        end
    endtask

    task automatic test_dc();
        do_reset();
        for (int i = 0; i < 16; i++) send(10000);
        wait_out(8);
        tests++; if (outq[0] !== 22'sd156) begin fails++; $display("FAIL dc10000_first: got %0d required 156", outq[0]); end
        for (int i = 5; i < 8; i++) begin
            tests++;
            if (outq[i] !== 22'sd10000) begin fails++; $display("FAIL dc10000_%0d: got %0d required 10000", i, outq[i]); end
        end
        do_reset();
        for (int i = 0; i < 16; i++) send(2097151);
        wait_out(8);
        tests++; if (outq[0] !== 22'sd32768) begin fails++; $display("FAIL dcmax_first: got %0d required 32768", outq[0]); end
        for (int i = 5; i < 8; i++) begin
            tests++;
            if (outq[i] !== 22'sd2097151) begin fails++; $display("FAIL dcmax_%0d: got %0d required 2097151", i, outq[i]); end
        end
    endtask

    task automatic test_saturation();
        int s[12];
        s = '{0, 2097151, 0, -2097152, 0, 2097151, 2097151, 2097151, 0, -2097152, 0, 2097151};
        do_reset();
        for (int i = 0; i < 12; i++) send(s[i]);
        wait_out(6);
        tests++; if (outq[5] !== 22'sd2097151) begin fails++; $display("FAIL sat_pos: got %0d required 2097151", outq[5]); end
        s = '{0, -2097152, 0, 2097151, 0, -2097152, -2097152, -2097152, 0, 2097151, 0, -2097152};
        do_reset();
        for (int i = 0; i < 12; i++) send(s[i]);
        wait_out(6);
        tests++; if (outq[5] !== -22'sd2097152) begin fails++; $display("FAIL sat_neg: got %0d required -2097152", outq[5]); end
    endtask

    task automatic test_overrun();
        do_reset();
        send(0);
        send(64);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = 22'd5000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %0b required 1", overrun); end
        wait_out(1);
        tests++; if (outq[0] !== 22'sd1) begin fails++; $display("FAIL ovr_out0: got %0d required 1", outq[0]); end
        send(0);
        send(0);
        wait_out(2);
        tests++; if (outq[1] !== -22'sd5) begin fails++; $display("FAIL ovr_out1: got %0d required -5", outq[1]); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %0b required 1", overrun); end
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %0b required 0", overrun); end
        send(0);
        send(0);
        @(negedge clk);
        in_valid = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        overrun_clr = 1'b0;
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set_wins: got %0b required 1", overrun); end
    endtask

    task automatic test_latency();
        int a;
        int low;
        do_reset();
        send(0);
        send(64);
        a = accq[1];
        low = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!in_ready) low++;
            else break;
        end
        wait_out(1);
        tests++; if (low !== 8) begin fails++; $display("FAIL lat_ready_low: got %0d cycles required 8", low); end
        tests++; if (outcyc[0] - a !== 8) begin fails++; $display("FAIL lat_cycles: got %0d required 8", outcyc[0] - a); end
        tests++; if (outq[0] !== 22'sd1) begin fails++; $display("FAIL lat_value: got %0d required 1", outq[0]); end
        repeat (5) @(negedge clk);
        tests++; if (outq.size() !== 1) begin fails++; $display("FAIL lat_single_pulse: got %0d pulses required 1", outq.size()); end
        tests++; if (out_data !== 22'd1) begin fails++; $display("FAIL lat_hold: got %0d required 1", out_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(0);
        send(64);
        send(0);
        send(0);
        send(0);
        send(0);
        wait_out(3);
        tests++; if (accq[2] - accq[1] !== 9) begin fails++; $display("FAIL b2b_spacing: got %0d required 9", accq[2] - accq[1]); end
        tests++; if (accq[3] - accq[2] !== 1) begin fails++; $display("FAIL b2b_pair: got %0d required 1", accq[3] - accq[2]); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_no_drop: got %0b required 0", overrun); end
        tests++; if (outq[0] !== 22'sd1) begin fails++; $display("FAIL b2b_out0: got %0d required 1", outq[0]); end
        tests++; if (outq[1] !== -22'sd5) begin fails++; $display("FAIL b2b_out1: got %0d required -5", outq[1]); end
        tests++; if (outq[2] !== 22'sd20) begin fails++; $display("FAIL b2b_out2: got %0d required 20", outq[2]); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_rounding();
        test_dc();
        test_saturation();
        test_overrun();
        test_latency();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
